// File: rtl/digit_scan_mux.sv
// digit_scan_mux: time-multiplexed digit scanner for a multi-digit 7-segment
// display. A refresh prescaler steps a one-hot anode scan. The digit word is
// snapshotted at every frame wrap so that a frame never mixes two values. All
// outputs are registered.
// Optional feature macro: DIGIT_SCAN_LZB_EN (leading-zero blanking from the snapshot).
module digit_scan_mux #(
    parameter int NUM_DIGITS  = 3,
    parameter int DIGIT_W     = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]   digits_i,
    output logic [NUM_DIGITS-1:0]           an_o,
    output logic [DIGIT_W-1:0]              digit_o,
    output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx_o,
    output logic                            blank_o,
    output logic                            frame_done_o
);

    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int WORD_W = NUM_DIGITS * DIGIT_W;

    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      r_count;
    logic [IDX_W-1:0]      r_idx;
    logic [WORD_W-1:0]     r_snap;
    logic [NUM_DIGITS-1:0] r_an;
    logic [DIGIT_W-1:0]    r_digit;
    logic                  r_frame_done;

    logic                  w_tick;
    logic                  w_wrap;
    logic [IDX_W-1:0]      w_idx_next;
    logic [WORD_W-1:0]     w_snap_next;
    logic [NUM_DIGITS-1:0] w_an_next;
    logic [DIGIT_W-1:0]    w_digit_next;
    logic [NUM_DIGITS-1:0] w_an_out;
    logic [DIGIT_W-1:0]    w_digit_out;

    // A tick ends the current digit slot; a wrap is the tick that ends the frame.
    assign w_tick = en && (r_count == CNT_TOP);
    assign w_wrap = w_tick && (r_idx == IDX_TOP);

    // Index and snapshot as they will be after this edge. The registered outputs
    // are loaded from these values, so digit 0 of a new frame already shows the
    // freshly captured word.
    assign w_idx_next  = w_wrap ? '0 : (r_idx + IDX_W'(1));
    assign w_snap_next = w_wrap ? digits_i : r_snap;
    assign w_an_next   = NUM_DIGITS'(1) << w_idx_next;

    // Select the nibble of the upcoming digit from the (next) snapshot.
    always_comb begin
        w_digit_next = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_idx_next == IDX_W'(k)) begin
                w_digit_next = w_snap_next[k*DIGIT_W +: DIGIT_W];
            end
        end
    end

`ifdef DIGIT_SCAN_LZB_EN
    logic [NUM_DIGITS-1:0] w_blank_vec;
    logic                  w_upper_zero;
    logic                  w_blank_next;
    logic                  r_blank;

    // Digit k (k != 0) is blanked when it and every more significant digit are zero.
    always_comb begin
        w_blank_vec  = '0;
        w_upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_upper_zero   = w_upper_zero && (w_snap_next[k*DIGIT_W +: DIGIT_W] == '0);
            w_blank_vec[k] = w_upper_zero;
        end
    end

    assign w_blank_next = |(w_blank_vec & w_an_next);
    assign w_an_out     = w_blank_next ? '0 : w_an_next;
    assign w_digit_out  = w_blank_next ? '0 : w_digit_next;

    // Blank flag is registered with the other outputs and changes only on a tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blank <= 1'b0;
        end else if (w_tick) begin
            r_blank <= w_blank_next;
        end
    end

    assign blank_o = r_blank;
`else
    assign w_an_out    = w_an_next;
    assign w_digit_out = w_digit_next;
    assign blank_o     = 1'b0;
`endif

    // Refresh prescaler: counts 0..REFRESH_DIV-1 while enabled, holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (en) begin
            if (r_count == CNT_TOP) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    // Scan index and frame snapshot; the snapshot is reloaded only on a wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_snap <= '0;
        end else if (w_tick) begin
            r_idx  <= w_idx_next;
            r_snap <= w_snap_next;
        end
    end

    // Registered display outputs; frame_done pulses on the edge that returns to digit 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_an         <= NUM_DIGITS'(1);
            r_digit      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_wrap;
            if (w_tick) begin
                r_an    <= w_an_out;
                r_digit <= w_digit_out;
            end
        end
    end

    assign an_o         = r_an;
    assign digit_o      = r_digit;
    assign digit_idx_o  = r_idx;
    assign frame_done_o = r_frame_done;

endmodule

// File: tb/tb_digit_scan_mux.sv
// Self-checking bench for digit_scan_mux (NUM_DIGITS=3, DIGIT_W=4, REFRESH_DIV=4).
// Expected output vectors are pushed into a queue and popped one per cycle.
module tb_digit_scan_mux;

  localparam int ND = 3;
  localparam int DW = 4;
  localparam int RD = 4;
  localparam int IW = 2;
  localparam int VW = ND + DW + IW + 2;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic [ND*DW-1:0] digits_i;
  logic [ND-1:0] an_o;
  logic [DW-1:0] digit_o;
  logic [IW-1:0] digit_idx_o;
  logic blank_o;
  logic frame_done_o;

  int checks = 0;
  int errors = 0;
  logic [VW-1:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  digit_scan_mux #(
    .NUM_DIGITS (ND),
    .DIGIT_W    (DW),
    .REFRESH_DIV(RD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .digits_i    (digits_i),
    .an_o        (an_o),
    .digit_o     (digit_o),
    .digit_idx_o (digit_idx_o),
    .blank_o     (blank_o),
    .frame_done_o(frame_done_o)
  );

  // expected {an, digit, idx, blank, frame_done} for digit idx of a frame showing snap
  function automatic logic [VW-1:0] model(input int idx, input logic [ND*DW-1:0] snap,
                                          input logic fd);
    logic [ND-1:0] an;
    logic [DW-1:0] d;
    logic bl;
    an = ND'(1) << idx;
    d  = snap[idx*DW +: DW];
    bl = 1'b0;
`ifdef DIGIT_SCAN_LZB_EN
    if (idx != 0) begin
      bl = 1'b1;
      for (int k = idx; k < ND; k++) begin
        if (snap[k*DW +: DW] != '0) bl = 1'b0;
      end
    end
    if (bl) begin
      an = '0;
      d  = '0;
    end
`endif
    return {an, d, IW'(idx), bl, fd};
  endfunction

  // scoreboard: pop one expected vector and compare against the current outputs
  task automatic check_now(input string tag);
    logic [VW-1:0] exp;
    logic [VW-1:0] obs;
    obs = {an_o, digit_o, digit_idx_o, blank_o, frame_done_o};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %h expected <empty queue>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  // driver: expect n cycles of one digit slot, then step the clock n times
  task automatic slot(input string tag, input int idx, input logic [ND*DW-1:0] snap,
                      input logic fd_first, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(model(idx, snap, fd_first && (i == 0)));
    for (int i = 0; i < n; i++) begin
      check_now(tag);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input string tag, input logic [ND*DW-1:0] snap);
    slot(tag, 0, snap, 1'b1, RD);
    slot(tag, 1, snap, 1'b0, RD);
    slot(tag, 2, snap, 1'b0, RD);
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [ND*DW-1:0] cur;
    logic [ND*DW-1:0] nxt;

    // reset values
    rst_n    = 1'b0;
    en       = 1'b1;
    digits_i = 12'h123;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back({3'b001, 4'h0, 2'd0, 1'b0, 1'b0});
    check_now("reset");
    rst_n = 1'b1;

    // frame 1 shows the zero snapshot; no pulse at its start
    slot("f1_d0", 0, '0, 1'b0, RD);
    slot("f1_d1", 1, '0, 1'b0, RD);
    slot("f1_d2", 2, '0, 1'b0, RD);

    // frame 2 shows 0x123; input changes during digit 1 (anti-tearing)
    slot("f2_d0", 0, 12'h123, 1'b1, RD);
    digits_i = 12'h456;
    slot("f2_d1", 1, 12'h123, 1'b0, RD);
    slot("f2_d2", 2, 12'h123, 1'b0, RD);

    // frame 3 shows 0x456; enable held low for 10 cycles in digit 1
    slot("f3_d0", 0, 12'h456, 1'b1, RD);
    slot("f3_d1a", 1, 12'h456, 1'b0, 2);
    en = 1'b0;
    slot("f3_hold", 1, 12'h456, 1'b0, 10);
    en = 1'b1;
    slot("f3_d1b", 1, 12'h456, 1'b0, 2);
    slot("f3_d2", 2, 12'h456, 1'b0, RD);

    // frame 4 with a one-cycle reset during digit 2
    slot("f4_d0", 0, 12'h456, 1'b1, RD);
    slot("f4_d1", 1, 12'h456, 1'b0, RD);
    slot("f4_d2", 2, 12'h456, 1'b0, 2);
    rst_n = 1'b0;
    slot("f4_rst", 2, 12'h456, 1'b0, 1);
    rst_n = 1'b1;

    // restarted frame shows zero snapshot; en drops exactly at the top count of digit 1
    slot("r1_d0", 0, '0, 1'b0, RD);
    slot("r1_d1a", 1, '0, 1'b0, 3);
    en = 1'b0;
    slot("r1_top_hold", 1, '0, 1'b0, 5);
    en = 1'b1;
    slot("r1_top_tick", 1, '0, 1'b0, 1);
    slot("r1_d2", 2, '0, 1'b0, RD);

    // random input changing every cycle; only the value at the final tick counts
    cur = 12'h456;
    for (int f = 0; f < 3; f++) begin
      nxt = '0;
      for (int s = 0; s < ND; s++) begin
        for (int c = 0; c < RD; c++) begin
          digits_i = 12'($urandom_range(0, 4095));
          if (s == ND - 1 && c == RD - 1) nxt = digits_i;
          exp_q.push_back(model(s, cur, (s == 0) && (c == 0)));
          check_now("rand");
          @(posedge clk);
          #1;
        end
      end
      cur = nxt;
    end

    // leading-zero patterns (blanked only when the feature is built in)
    digits_i = 12'h005;
    frame("pre_005", cur);
    digits_i = 12'h000;
    frame("lzb_005", 12'h005);
    digits_i = 12'h105;
    frame("lzb_000", 12'h000);
    frame("lzb_105", 12'h105);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_scan_mux.md
# digit_scan_mux

Time-multiplexed digit scanner for the multi-digit 7-segment display path. It replaces the combinational one-hot digit mux and its external one-hot sequencer with a single block. The block generates the one-hot anode scan internally from a refresh prescaler and selects the matching digit nibble. It also double-buffers the digit word at frame boundaries so a frame never shows digits from two different values, and it registers all outputs. It sits between the BCD conversion stage and the segment decoder.

## Interface
Parameters:
- NUM_DIGITS, 3, number of display digits scanned; legal range ≥ 2.
- DIGIT_W, 4, bits per digit (BCD nibble by default).
- REFRESH_DIV, 50000, clock cycles each digit stays active; legal range ≥ 1.

Ports:
- clk  input  1  system clock; one clock domain only.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- en  input  1  scan enable; when low, the scan freezes.
- digits_i  input  NUM_DIGITS*DIGIT_W  digit word; digit k = digits_i[k*DIGIT_W +: DIGIT_W]; digit 0 = units (least significant).
- an_o  output  NUM_DIGITS  one-hot active digit select, active-high; bit k = digit k.
- digit_o  output  DIGIT_W  value of the active digit.
- digit_idx_o  output  $clog2(NUM_DIGITS)  binary index of the active digit.
- blank_o  output  1  active digit is blanked (leading-zero blanking only).
- frame_done_o  output  1  one-cycle pulse when the scan wraps back to digit 0.

## Operation
- Prescaler: counter of width max(1, $clog2(REFRESH_DIV)) counting 0..REFRESH_DIV-1.
  - Wraps to 0 at the top count.
  - tick = en && (count == REFRESH_DIV-1).
  - With REFRESH_DIV = 1, tick = en on every cycle.
- Scan index: increments on tick and wraps from NUM_DIGITS-1 to 0.
  - an_o is always exactly one-hot, bit idx, except during blanking.
  - No invalid or out-of-range select state is reachable.
- Snapshot register (NUM_DIGITS*DIGIT_W bits):
  - Loads digits_i on a tick while idx == NUM_DIGITS-1, i.e. on the transition to digit 0.
  - Holds its value at all other times.
  - digit_o always comes from the snapshot, never directly from digits_i.
- frame_done_o: asserted for one cycle, coincident with the registered outputs switching to digit 0.
- en low:
  - Prescaler, index, snapshot and all outputs hold their values.
  - frame_done_o = 0.
  - Scanning resumes from the held prescaler count.
- Reset (rst_n = 0 at a clock edge), including mid-scan:
  - prescaler = 0, idx = 0, snapshot = 0.
  - an_o = 1 (digit 0 active), digit_o = 0, digit_idx_o = 0.
  - blank_o = 0, frame_done_o = 0.
  - Any frame in progress is abandoned.

## Timing
- All outputs are registered.
- Outputs change on the clock edge that samples tick = 1 (one cycle of latency after the count reaches its top value).
- With en held high, each digit is active for exactly REFRESH_DIV cycles; a frame lasts NUM_DIGITS*REFRESH_DIV cycles.
- After reset release with en = 1:
  - Digit 0 is active for cycles 0..REFRESH_DIV-1.
  - The first frame shows the reset snapshot (all zeros).
  - digits_i first appears at frame 2, as sampled on the final tick of frame 1.
- digits_i may change on any cycle. Only its value on the final tick of a frame is used, so digits_i needs no handshake or stability requirement.
- en falling on the same cycle as the top count: no tick occurs; the count stays at REFRESH_DIV-1 and ticks on the first cycle en returns high.

## Configuration
- Macro: DIGIT_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - Digit k (k ≠ 0) is blanked when snapshot digits k..NUM_DIGITS-1 are all zero.
  - A blanked digit drives an_o = 0, digit_o = 0 and blank_o = 1 for its whole slot.
  - Slot timing and the scan index are unchanged.
  - Digit 0 is never blanked.
  - Blanking is computed from the snapshot, so it is frame-coherent.
- Undefined: blank_o is tied to 0 and no digit is ever blanked; there is no blanking logic.

## Test plan
- Reset values: hold rst_n = 0 for 3 cycles with digits_i = 0x123, then check an_o = 001, digit_o = 0, digit_idx_o = 0, blank_o = 0, frame_done_o = 0.
- Basic scan (NUM_DIGITS = 3, REFRESH_DIV = 4, en = 1, digits_i = 0x123):
  - Frame 1 shows 0 on an_o = 001 → 010 → 100, 4 cycles each.
  - frame_done_o pulses at cycle 12.
  - Frame 2 shows 3/001, 2/010, 1/100, 4 cycles each.
- Anti-tearing: change digits_i from 0x123 to 0x456 during digit 1 of frame 2.
  - Frame 2 still shows 3, 2, 1.
  - Frame 3 shows 6, 5, 4.
- Enable hold: drop en for 10 cycles during digit 1. The outputs and count freeze, and digit 1 stays active for 4 + 10 enabled-plus-held cycles, exactly 4 enabled cycles in total.
- Mid-scan reset: assert rst_n = 0 for 1 cycle during digit 2. The outputs return to their reset values, and the next frame restarts at digit 0 with the snapshot = 0.
- With DIGIT_SCAN_LZB_EN defined:
  - digits_i = 0x005 → digits 2 and 1 blanked (an_o = 000, blank_o = 1), digit 0 shows 5.
  - digits_i = 0x000 → only digit 0 is lit, showing 0.
  - digits_i = 0x105 → no blanking.
